onehot_decoder_seq: RTL and testbench
=====================================

Name: onehot_decoder_seq

Overview:
- Registered, parametrised N-to-OUT_W one-hot decoder with valid/ready handshakes on both sides.
- Two modes:
  - Single: one decoded beat per request.
  - Sweep: a walking-one sequence from the requested index up to OUT_W-1.
- Drives row/column selects and scan strobes in lab datapaths.
- Out-of-range indices produce an all-zero output with an error flag, never high-impedance.

Parameters:
- SEL_W, 3, width of the select index.
- OUT_W, 8, number of one-hot output lines. Must satisfy 2 <= OUT_W <= 2**SEL_W.

Ports:
- clk  in  1  system clock. Rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request.
- in_sel  in  SEL_W  start index.
- in_sweep  in  1  0 = single beat, 1 = sweep from in_sel to OUT_W-1.
- out_valid  out  1  y holds a valid beat.
- out_ready  in  1  consumer accepts the beat.
- y  out  OUT_W  one-hot decoded output. All-zero when idle or on error.
- out_last  out  1  final beat of the current request.
- out_err  out  1  beat came from an out-of-range index.
- busy  out  1  request in progress (state != IDLE).

Behaviour:
- Reset (rst=1 at clk edge):
  - State goes to IDLE.
  - Outputs: y=0, out_valid=0, out_last=0, out_err=0, busy=0, in_ready=1.
  - rst mid-sweep abandons the sweep immediately; no further beats are emitted.
- Accept: a request is taken when in_valid && in_ready at a clk edge. in_ready=1 only in IDLE, so there is no overlap between requests.
- Latency: first beat appears with out_valid=1 in the cycle after accept, i.e. one register stage.
- States:
  - IDLE: in_ready=1, out_valid=0, y=0.
    - Accept with in_sel >= OUT_W -> ERR.
    - Accept with in_sweep=0 -> SINGLE.
    - Accept with in_sweep=1 -> SWEEP; the index register idx is loaded with in_sel.
  - SINGLE: y = 1<<idx, out_last=1. On out_ready -> IDLE.
  - SWEEP: y = 1<<idx, out_last = (idx == OUT_W-1).
    - On out_ready with out_last=0: idx increments by 1 and the state stays in SWEEP.
    - On out_ready with out_last=1 -> IDLE.
  - ERR: y=0, out_err=1, out_last=1, one beat regardless of in_sweep. On out_ready -> IDLE.
- Output hold: while out_valid=1 && out_ready=0, y, out_last and out_err are held stable.
- Beat count: sweep from in_sel=s emits exactly OUT_W-s beats. idx never wraps past OUT_W-1.
- Width of idx: SEL_W bits. The comparison against OUT_W is performed at SEL_W+1 bits, so OUT_W = 2**SEL_W is handled correctly.
- Back-to-back requests: after the last beat handshake, the state returns to IDLE and in_ready=1 in the next cycle. Minimum spacing is one idle cycle between requests.
- Inputs in_sel and in_sweep are sampled only at accept. Changes at any other time are ignored.
- busy=1 in SINGLE, SWEEP and ERR.

Optional Feature:
- Macro: ONEHOT_DEC_ERRCNT_EN.
- Defined:
  - Adds output port err_cnt (out, 8 bits).
  - err_cnt increments by 1 on each accepted out-of-range request and saturates at 255.
  - Cleared by rst.
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

Decomposition:
- Package onehot_dec_pkg holds:
  - State enum: IDLE, SINGLE, SWEEP, ERR (2-bit encoding).
  - Localparam ERRCNT_W = 8.
  - Function onehot(idx, width) returning the one-hot vector.
- Sub-module onehot_dec_core: purely combinational idx -> y one-hot with range check (outputs y and err_raw). Instantiated once in the top.

Test Plan:
1. Reset behaviour: assert rst mid-sweep (SEL_W=3, OUT_W=8, in_sel=2, after 2 beats) -> next cycle y=0, out_valid=0, busy=0, in_ready=1, no further beats.
2. Single mode: in_sel=5, in_sweep=0, out_ready=1 -> one cycle later y=8'b00100000, out_last=1; next cycle in_ready=1.
3. Sweep with backpressure: in_sel=5, in_sweep=1, out_ready toggled 1,0,1,1 -> beats 0x20, 0x40 (held for 2 cycles), 0x80 with out_last=1; exactly 3 beats.
4. Range error: SEL_W=3, OUT_W=6, in_sel=7, in_sweep=1 -> single beat, y=0, out_err=1, out_last=1; with ONEHOT_DEC_ERRCNT_EN defined, err_cnt goes 0 -> 1.
5. Edge index: in_sel=OUT_W-1, in_sweep=1 -> exactly one beat, y=MSB set, out_last=1. Also in_sel=0, in_sweep=1 -> exactly 8 beats walking 0x01 to 0x80.
6. Ignored inputs: in_valid held high while busy, with in_sel changing -> no new accept until IDLE; the sweep sequence is unaffected. Also: 300 range errors with the macro defined -> err_cnt saturates at 255.

Source files
------------

// File: rtl/onehot_dec_pkg.sv
// Shared types, constants and the one-hot helper for onehot_decoder_seq.
package onehot_dec_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SINGLE = 2'd1,
      SWEEP  = 2'd2,
      ERR    = 2'd3
   } state_t;

   localparam int unsigned ERRCNT_W  = 8;
   localparam int unsigned MAX_OUT_W = 256;

   // Indices at or above width yield an all-zero vector; callers truncate to their own width.
   function automatic logic [MAX_OUT_W-1:0] onehot(input int unsigned idx, input int unsigned width);
      logic [MAX_OUT_W-1:0] v;
      v = '0;
      for (int unsigned i = 0; i < MAX_OUT_W; i++) begin
         if (i == idx && i < width) v[i] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/onehot_dec_core.sv
// Combinational index-to-one-hot decode with out-of-range detection.
module onehot_dec_core
   import onehot_dec_pkg::*;
#(
   parameter int unsigned SEL_W = 3,
   parameter int unsigned OUT_W = 8
) (
   input  logic [SEL_W-1:0] idx,
   output logic [OUT_W-1:0] y,
   output logic             err_raw
);

   // One extra bit so OUT_W = 2**SEL_W is representable.
   localparam logic [SEL_W:0] OUT_W_EXT = (SEL_W+1)'(OUT_W);

   always_comb begin
      y       = OUT_W'(onehot(32'(idx), OUT_W));
      err_raw = ({1'b0, idx} >= OUT_W_EXT);
   end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered one-hot decoder with single/sweep modes and valid/ready handshakes.
// Define ONEHOT_DEC_ERRCNT_EN to add the saturating err_cnt output.
module onehot_decoder_seq
   import onehot_dec_pkg::*;
#(
   parameter int unsigned SEL_W = 3,
   parameter int unsigned OUT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [SEL_W-1:0]    in_sel,
   input  logic                in_sweep,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [OUT_W-1:0]    y,
   output logic                out_last,
   output logic                out_err,
`ifdef ONEHOT_DEC_ERRCNT_EN
   output logic [ERRCNT_W-1:0] err_cnt,
`endif
   output logic                busy
);

   localparam logic [SEL_W:0] LAST_IDX = (SEL_W+1)'(OUT_W - 1);

   state_t           state, state_nxt;
   logic [SEL_W-1:0] idx, idx_nxt, core_idx;
   logic [OUT_W-1:0] core_y;
   logic             core_err;
   logic             idx_last;
   logic             accept;

   // The single decoder checks in_sel while idle and decodes the held index otherwise.
   assign core_idx = (state == IDLE) ? in_sel : idx;
   assign idx_last = ({1'b0, idx} == LAST_IDX);
   assign accept   = (state == IDLE) && in_valid;

   onehot_dec_core #(
      .SEL_W (SEL_W),
      .OUT_W (OUT_W)
   ) u_core (
      .idx     (core_idx),
      .y       (core_y),
      .err_raw (core_err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      in_ready  = 1'b0;
      out_valid = 1'b1;
      busy      = 1'b1;
      y         = '0;
      out_last  = 1'b0;
      out_err   = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
            busy      = 1'b0;
            if (in_valid) begin
               idx_nxt = in_sel;
               if (core_err)      state_nxt = ERR;
               else if (in_sweep) state_nxt = SWEEP;
               else               state_nxt = SINGLE;
            end
         end
         SINGLE: begin
            y        = core_y;
            out_last = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         SWEEP: begin
            y        = core_y;
            out_last = idx_last;
            if (out_ready) begin
               if (idx_last) state_nxt = IDLE;
               else          idx_nxt   = idx + 1'b1;
            end
         end
         ERR: begin
            out_err  = 1'b1;
            out_last = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef ONEHOT_DEC_ERRCNT_EN
   always_ff @(posedge clk) begin
      if (rst)                                       err_cnt <= '0;
      else if (accept && core_err && err_cnt != '1)  err_cnt <= err_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Self-checking bench: an 8-output and a 6-output decoder against a beat-list reference model.
module tb_onehot_decoder_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       iv   [2];
   logic [2:0] isel [2];
   logic       isw  [2];
   logic       ordy [2];
   logic       ir   [2];
   logic       ov   [2];
   logic       ol   [2];
   logic       oe   [2];
   logic       bz   [2];
   logic [7:0] y8;
   logic [5:0] y6;
`ifdef ONEHOT_DEC_ERRCNT_EN
   logic [7:0] ec   [2];
`endif

   int nvec = 0;
   int nerr = 0;
   int ecm [2];

   always #5 clk = ~clk;

   onehot_decoder_seq #(.SEL_W(3), .OUT_W(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_sel(isel[0]),
      .in_sweep(isw[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .y(y8),
      .out_last(ol[0]), .out_err(oe[0]),
`ifdef ONEHOT_DEC_ERRCNT_EN
      .err_cnt(ec[0]),
`endif
      .busy(bz[0])
   );

   onehot_decoder_seq #(.SEL_W(3), .OUT_W(6)) u_dut6 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_sel(isel[1]),
      .in_sweep(isw[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .y(y6),
      .out_last(ol[1]), .out_err(oe[1]),
`ifdef ONEHOT_DEC_ERRCNT_EN
      .err_cnt(ec[1]),
`endif
      .busy(bz[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] get_y(input int which);
      return (which != 0) ? {2'b00, y6} : y8;
   endfunction

   task automatic chk_idle(input int which);
      chk("idle_valid", {31'd0, ov[which]}, 0);
      chk("idle_y",     {24'd0, get_y(which)}, 0);
      chk("idle_busy",  {31'd0, bz[which]}, 0);
      chk("idle_ready", {31'd0, ir[which]}, 1);
      chk("idle_last",  {31'd0, ol[which]}, 0);
      chk("idle_err",   {31'd0, oe[which]}, 0);
`ifdef ONEHOT_DEC_ERRCNT_EN
      chk("err_cnt",    {24'd0, ec[which]}, ecm[which]);
`endif
   endtask

   // Expected beats follow from the request alone: an out-of-range index gives one error beat,
   // a sweep gives indices s..W-1, otherwise one beat at s.
   task automatic run_req(input int which, input int s, input bit sweep, input bit noise,
                          input logic [31:0] rpat, input int rlen);
      int w, nb, k, cyc, bit_i;
      logic [7:0] ey;
      bit el, ee, r;
      w = (which != 0) ? 6 : 8;
      @(negedge clk);
      chk("accept_ready", {31'd0, ir[which]}, 1);
      iv[which]   = 1'b1;
      isel[which] = 3'(s);
      isw[which]  = sweep;
      if (s >= w) begin
         nb = 1;
         if (ecm[which] < 255) ecm[which]++;
      end else begin
         nb = sweep ? (w - s) : 1;
      end
      k   = 0;
      cyc = 0;
      @(negedge clk);
      if (!noise) iv[which] = 1'b0;
      while (k < nb && cyc < 200) begin
         if (noise) begin
            isel[which] = 3'($urandom_range(0, 7));
            isw[which]  = 1'($urandom_range(0, 1));
         end
         if (s >= w) begin
            ey = 8'h00; el = 1'b1; ee = 1'b1;
         end else begin
            bit_i = sweep ? (s + k) : s;
            ey = 8'(2 ** bit_i);
            el = (k == nb - 1);
            ee = 1'b0;
         end
         chk("beat_valid", {31'd0, ov[which]}, 1);
         chk("beat_y",     {24'd0, get_y(which)}, {24'd0, ey});
         chk("beat_last",  {31'd0, ol[which]}, {31'd0, el});
         chk("beat_err",   {31'd0, oe[which]}, {31'd0, ee});
         chk("beat_busy",  {31'd0, bz[which]}, 1);
         chk("beat_noacc", {31'd0, ir[which]}, 0);
         r = (cyc < rlen) ? rpat[cyc] : 1'($urandom_range(0, 1));
         ordy[which] = r;
         @(negedge clk);
         if (r) k++;
         cyc++;
      end
      if (k < nb) chk("beat_budget", k, nb);
      ordy[which] = 1'b0;
      chk_idle(which);
      iv[which] = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         iv[i] = 1'b0; isel[i] = '0; isw[i] = 1'b0; ordy[i] = 1'b0; ecm[i] = 0;
      end
      repeat (2) @(negedge clk);
      chk_idle(0);
      chk_idle(1);
      rst = 1'b0;

      // Reset in the middle of a sweep from index 2 after two beats.
      @(negedge clk);
      iv[0] = 1'b1; isel[0] = 3'd2; isw[0] = 1'b1;
      @(negedge clk);
      iv[0] = 1'b0; ordy[0] = 1'b1;
      chk("rst_b0", {24'd0, y8}, 32'h04);
      @(negedge clk);
      chk("rst_b1", {24'd0, y8}, 32'h08);
      @(negedge clk);
      chk("rst_b2", {24'd0, y8}, 32'h10);
      rst = 1'b1;
      ecm[0] = 0; ecm[1] = 0;
      @(negedge clk);
      rst = 1'b0;
      chk_idle(0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_nobeat", {31'd0, ov[0]}, 0);
      end
      ordy[0] = 1'b0;

      run_req(0, 5, 1'b0, 1'b0, 32'h1, 1);      // single beat
      run_req(0, 5, 1'b1, 1'b0, 32'hD, 4);      // ready 1,0,1,1
      run_req(1, 7, 1'b1, 1'b0, 32'h1, 1);      // out of range
      run_req(0, 7, 1'b1, 1'b0, 32'h1, 1);      // top index
      run_req(0, 0, 1'b1, 1'b0, 32'hFF, 8);     // full walk
      run_req(0, 1, 1'b1, 1'b1, 32'h0, 0);      // in_valid held, in_sel wandering
      run_req(1, 5, 1'b1, 1'b0, 32'h0, 0);
      run_req(1, 6, 1'b0, 1'b0, 32'h0, 0);

      for (int i = 0; i < 300; i++) begin
         run_req(1, 6 + (i % 2), (i % 3) == 0, 1'b0, 32'h1, 1);
      end

      for (int i = 0; i < 40; i++) begin
         run_req(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
